// File: rtl/bconv_pkg.sv
// Shared constants and types for the binary convolution layer sequencer.
package bconv_pkg;

  localparam int IMG_W  = 28;
  localparam int K      = 3;
  localparam int OUT_W  = IMG_W - K + 1;
  localparam int KERN_W = K * K;
  localparam int PCNT_W = 4;
  localparam int ROW_W  = $clog2(OUT_W);
  localparam int IR_W   = $clog2(IMG_W);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_KERN,
    S_LOAD_IMG,
    S_RUN,
    S_DONE
  } bconv_state_t;

  // Index width for a bank of n kernels; a single kernel still gets one bit.
  function automatic int kidx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bconv_layer_ctrl_if.sv
// Kernel, image-row and output-row streams of the binary convolution layer.
interface bconv_layer_ctrl_if
  import bconv_pkg::*;
#(
  parameter int NUM_KERNELS = 4
) ();

  localparam int KIDX_W = kidx_width(NUM_KERNELS);

  logic              kern_valid;
  logic              kern_ready;
  logic [KERN_W-1:0] kern_data;

  logic              img_row_valid;
  logic              img_row_ready;
  logic [IMG_W-1:0]  img_row_data;

  logic              out_valid;
  logic              out_ready;
  logic [OUT_W-1:0]  out_data;
  logic [KIDX_W-1:0] out_kidx;
  logic [ROW_W-1:0]  out_row;

  modport master (
    output kern_valid, kern_data, img_row_valid, img_row_data, out_ready,
    input  kern_ready, img_row_ready, out_valid, out_data, out_kidx, out_row
  );

  modport slave (
    input  kern_valid, kern_data, img_row_valid, img_row_data, out_ready,
    output kern_ready, img_row_ready, out_valid, out_data, out_kidx, out_row
  );

endinterface

// File: rtl/bconv_layer_ctrl_row_unit.sv
// One output row of the binary convolution: XNOR-popcount-threshold per 3x3 window.

module bconv_window
  import bconv_pkg::*;
(
  input  logic [KERN_W-1:0] win,
  input  logic [KERN_W-1:0] kern,
  input  logic [PCNT_W-1:0] thresh,
  output logic              bit_out
);

  logic [KERN_W-1:0] agree;
  logic [PCNT_W-1:0] pcnt;

  // Count pixel/kernel agreements and compare unsigned against the threshold.
  always_comb begin
    agree = ~(win ^ kern);
    pcnt  = '0;
    for (int i = 0; i < KERN_W; i++) begin
      pcnt = pcnt + PCNT_W'(agree[i]);
    end
    bit_out = (pcnt >= thresh);
  end

endmodule

module bconv_row_unit
  import bconv_pkg::*;
(
  input  logic [IMG_W-1:0]  row0,
  input  logic [IMG_W-1:0]  row1,
  input  logic [IMG_W-1:0]  row2,
  input  logic [KERN_W-1:0] kern,
  input  logic [PCNT_W-1:0] thresh,
  output logic [OUT_W-1:0]  row_out
);

  // Window bit 3r+c is pixel (r, x+c), matching the kernel bit layout.
  for (genvar x = 0; x < OUT_W; x++) begin : g_win
    bconv_window u_win (
      .win     ({row2[x+2:x], row1[x+2:x], row0[x+2:x]}),
      .kern    (kern),
      .thresh  (thresh),
      .bit_out (row_out[x])
    );
  end

endmodule

// File: rtl/bconv_layer_ctrl.sv
// Sequencer for one binary convolution layer: load kernels, load image,
// sweep every kernel over every output row, then pulse done.
//
//  state       | meaning
//  ------------+-----------------------------------------------
//  S_IDLE      | waiting for start
//  S_LOAD_KERN | accepting NUM_KERNELS kernels
//  S_LOAD_IMG  | accepting IMG_W image rows
//  S_RUN       | presenting output row (k, y), one per handshake
//  S_DONE      | one-cycle done pulse
module bconv_layer_ctrl
  import bconv_pkg::*;
#(
  parameter int NUM_KERNELS = 4,
  parameter int THRESH      = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic               busy,
  output logic               done,
  bconv_layer_ctrl_if.slave  bus
);

  localparam int KIDX_W = kidx_width(NUM_KERNELS);
  localparam logic [KIDX_W-1:0] KC_LAST = KIDX_W'(NUM_KERNELS - 1);
  localparam logic [IR_W-1:0]   IR_LAST = IR_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0]  Y_LAST  = ROW_W'(OUT_W - 1);

  bconv_state_t state_q, state_d;

  logic [KIDX_W-1:0] kc_q, kc_d;
  logic [IR_W-1:0]   ir_q, ir_d;
  logic [KIDX_W-1:0] k_q, k_d;
  logic [ROW_W-1:0]  y_q, y_d;
  logic              out_load;
  logic              kern_we;
  logic              img_we;

  logic [KERN_W-1:0] kern_buf [NUM_KERNELS];
  logic [IMG_W-1:0]  img_buf  [IMG_W];

  logic [IR_W-1:0]   r0_idx, r1_idx, r2_idx;
  logic [OUT_W-1:0]  row_nxt;
  logic [OUT_W-1:0]  out_data_q;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next state, counter updates and state-decoded handshake outputs.
  always_comb begin
    state_d           = state_q;
    kc_d              = kc_q;
    ir_d              = ir_q;
    k_d               = k_q;
    y_d               = y_q;
    out_load          = 1'b0;
    kern_we           = 1'b0;
    img_we            = 1'b0;
    busy              = 1'b1;
    done              = 1'b0;
    bus.kern_ready    = 1'b0;
    bus.img_row_ready = 1'b0;
    bus.out_valid     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_d = S_LOAD_KERN;
          kc_d    = '0;
        end
      end
      S_LOAD_KERN: begin
        bus.kern_ready = 1'b1;
        if (bus.kern_valid) begin
          kern_we = 1'b1;
          kc_d    = kc_q + KIDX_W'(1);
          if (kc_q == KC_LAST) begin
            state_d = S_LOAD_IMG;
            ir_d    = '0;
          end
        end
      end
      S_LOAD_IMG: begin
        bus.img_row_ready = 1'b1;
        if (bus.img_row_valid) begin
          img_we = 1'b1;
          ir_d   = ir_q + IR_W'(1);
          if (ir_q == IR_LAST) begin
            // Row (0,0) only needs image rows 0..2, already buffered.
            state_d  = S_RUN;
            k_d      = '0;
            y_d      = '0;
            out_load = 1'b1;
          end
        end
      end
      S_RUN: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) begin
          if (k_q == KC_LAST && y_q == Y_LAST) begin
            state_d = S_DONE;
          end else begin
            out_load = 1'b1;
            if (y_q == Y_LAST) begin
              y_d = '0;
              k_d = k_q + KIDX_W'(1);
            end else begin
              y_d = y_q + ROW_W'(1);
            end
          end
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Load/run counters; k_q and y_q double as the presented row's tag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kc_q <= '0;
      ir_q <= '0;
      k_q  <= '0;
      y_q  <= '0;
    end else begin
      kc_q <= kc_d;
      ir_q <= ir_d;
      k_q  <= k_d;
      y_q  <= y_d;
    end
  end

  // Kernel and image buffers; never cleared, every run rewrites them fully.
  always_ff @(posedge clk) begin
    if (kern_we) kern_buf[kc_q] <= bus.kern_data;
    if (img_we)  img_buf[ir_q]  <= bus.img_row_data;
  end

  // The row unit evaluates the row about to be presented next.
  assign r0_idx = IR_W'(y_d);
  assign r1_idx = r0_idx + IR_W'(1);
  assign r2_idx = r0_idx + IR_W'(2);

  bconv_row_unit u_row (
    .row0    (img_buf[r0_idx]),
    .row1    (img_buf[r1_idx]),
    .row2    (img_buf[r2_idx]),
    .kern    (kern_buf[k_d]),
    .thresh  (PCNT_W'(THRESH)),
    .row_out (row_nxt)
  );

  // Output row register; holds while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        out_data_q <= '0;
    else if (out_load) out_data_q <= row_nxt;
  end

  assign bus.out_data = out_data_q;
  assign bus.out_kidx = k_q;
  assign bus.out_row  = y_q;

endmodule

// File: tb/tb_bconv_layer_ctrl.sv
// Bench for bconv_layer_ctrl: two instances (THRESH 5 and 0) driven in lockstep.
module tb_bconv_layer_ctrl;
  import bconv_pkg::*;

  localparam int NK    = 4;
  localparam int KW    = kidx_width(NK);
  localparam int NROWS = NK * OUT_W;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             kern_valid = 1'b0;
  logic [8:0]       kern_data = '0;
  logic             img_row_valid = 1'b0;
  logic [IMG_W-1:0] img_row_data = '0;
  logic             out_ready = 1'b0;
  logic             busy0, done0, busy1, done1;
  int               cyc = 0;

  bconv_layer_ctrl_if #(.NUM_KERNELS(NK)) b0 (), b1 ();

  assign b0.kern_valid    = kern_valid;
  assign b0.kern_data     = kern_data;
  assign b0.img_row_valid = img_row_valid;
  assign b0.img_row_data  = img_row_data;
  assign b0.out_ready     = out_ready;
  assign b1.kern_valid    = kern_valid;
  assign b1.kern_data     = kern_data;
  assign b1.img_row_valid = img_row_valid;
  assign b1.img_row_data  = img_row_data;
  assign b1.out_ready     = out_ready;

  bconv_layer_ctrl #(.NUM_KERNELS(NK), .THRESH(5)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy0), .done(done0), .bus(b0));
  bconv_layer_ctrl #(.NUM_KERNELS(NK), .THRESH(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy1), .done(done1), .bus(b1));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  int vec_count = 0;
  int err_count = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vec_count++;
    if (act !== exp) begin
      err_count++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference image and kernels for the current run.
  logic [8:0]       m_kern [NK];
  logic [IMG_W-1:0] m_img  [IMG_W];

  function automatic logic [OUT_W-1:0] model_row(input int k, input int y, input int th);
    logic [OUT_W-1:0] r;
    int cnt;
    r = '0;
    for (int x = 0; x < OUT_W; x++) begin
      cnt = 0;
      for (int rr = 0; rr < 3; rr++)
        for (int cc = 0; cc < 3; cc++)
          if (m_img[y+rr][x+cc] == m_kern[k][3*rr+cc]) cnt++;
      r[x] = (cnt >= th);
    end
    return r;
  endfunction

  typedef struct {
    logic [IMG_W-1:0] img_row;
    logic [8:0]       kern0;
    logic [OUT_W-1:0] exp_t5;
    logic [OUT_W-1:0] exp_t0;
  } vec_t;

  vec_t vt [4];
  bit               tbl_active = 0;
  logic [OUT_W-1:0] tbl_t5, tbl_t0;

  task automatic zero_outputs(input string name);
    check(name, 64'({busy0, done0, b0.kern_ready, b0.img_row_ready, b0.out_valid,
                     b0.out_data, b0.out_kidx, b0.out_row}), 64'(0));
  endtask

  // One layer run; abort_at >= 0 resets the DUTs after that many output rows.
  task automatic run_layer(input bit gaps, input bit stall, input bit spur,
                           input int abort_at, input bit time_check);
    int kc, ir, nrows, budget, t0, t_done, k_exp, y_exp;
    bit hs, stalled;
    logic [63:0] held;

    @(negedge clk);
    start = 1'b1;
    t0 = cyc;

    kc = 0; budget = 0;
    while (kc < NK && budget < 200) begin
      @(negedge clk);
      start = 1'b0;
      budget++;
      kern_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      kern_data  = m_kern[kc];
      #1 hs = kern_valid && b0.kern_ready;
      @(posedge clk);
      if (hs) kc++;
    end
    check("kernels_loaded", 64'(kc), 64'(NK));

    ir = 0; budget = 0;
    while (ir < IMG_W && budget < 400) begin
      @(negedge clk);
      budget++;
      kern_valid    = 1'b0;
      start         = spur && (ir == 10);
      img_row_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      img_row_data  = m_img[ir];
      #1 hs = img_row_valid && b0.img_row_ready;
      @(posedge clk);
      if (hs) ir++;
    end
    check("rows_loaded", 64'(ir), 64'(IMG_W));

    nrows = 0; budget = 0; k_exp = 0; y_exp = 0; stalled = 0; held = '0;
    while (nrows < NROWS && budget < 2000) begin
      @(negedge clk);
      budget++;
      img_row_valid = 1'b0;
      start = spur && (budget == 60);
      if (time_check && budget == 1) check("first_valid_latency", 64'(b0.out_valid), 64'(1));
      if (abort_at >= 0 && nrows >= abort_at) begin
        check("abort_in_run", 64'(b0.out_valid), 64'(1));
        #1 rst_n = 1'b0;
        #1 zero_outputs("reset_abort");
        @(negedge clk);
        zero_outputs("reset_hold");
        out_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      if (stalled)
        check("stall_hold", 64'({b0.out_valid, b0.out_data, b0.out_kidx, b0.out_row}), held);
      out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      stalled = 0;
      if (b0.out_valid) begin
        if (out_ready) begin
          check("row_data", 64'(b0.out_data), 64'(model_row(k_exp, y_exp, 5)));
          check("row_tag", 64'({b0.out_kidx, b0.out_row}), 64'({KW'(k_exp), ROW_W'(y_exp)}));
          check("row_data_t0", 64'({b1.out_valid, b1.out_data}),
                64'({1'b1, model_row(k_exp, y_exp, 0)}));
          if (tbl_active && k_exp == 0) begin
            check("tbl_k0_t5", 64'(b0.out_data), 64'(tbl_t5));
            check("tbl_k0_t0", 64'(b1.out_data), 64'(tbl_t0));
          end
          nrows++;
          y_exp++;
          if (y_exp == OUT_W) begin
            y_exp = 0;
            k_exp++;
          end
        end else begin
          stalled = 1;
          held = 64'({b0.out_valid, b0.out_data, b0.out_kidx, b0.out_row});
        end
      end
    end
    check("row_count", 64'(nrows), 64'(NROWS));
    if (time_check) check("run_no_bubbles", 64'(budget), 64'(NROWS));

    @(negedge clk);
    out_ready = 1'b0;
    start = spur;
    t_done = cyc;
    check("done_pulse", 64'({done0, b0.out_valid, busy0}), 64'(3'b101));
    if (time_check)
      check("start_to_done", 64'(t_done - t0 + 1), 64'(1 + NK + IMG_W + NROWS + 1));
    @(negedge clk);
    start = 1'b0;
    check("done_single", 64'({done0, busy0}), 64'(0));
    repeat (3) @(negedge clk);
    check("no_rerun", 64'({busy0, busy1}), 64'(0));
  endtask

  task automatic fill_random();
    for (int i = 0; i < NK; i++) m_kern[i] = 9'($urandom_range(0, 511));
    for (int r = 0; r < IMG_W; r++) m_img[r] = IMG_W'($urandom);
  endtask

  initial begin
    vt[0] = '{28'hAAAAAAA, 9'b101_010_101, 26'h2AAAAAA, 26'h3FFFFFF};
    vt[1] = '{28'hFFFFFFF, 9'h1FF,         26'h3FFFFFF, 26'h3FFFFFF};
    vt[2] = '{28'hFFFFFFF, 9'h000,         26'h0000000, 26'h3FFFFFF};
    vt[3] = '{28'h0000000, 9'h000,         26'h3FFFFFF, 26'h3FFFFFF};

    repeat (3) @(negedge clk);
    zero_outputs("reset_values");
    rst_n = 1'b1;

    for (int i = 0; i < 4; i++) begin
      fill_random();
      m_kern[0] = vt[i].kern0;
      for (int r = 0; r < IMG_W; r++) m_img[r] = vt[i].img_row;
      tbl_active = 1;
      tbl_t5 = vt[i].exp_t5;
      tbl_t0 = vt[i].exp_t0;
      run_layer(0, 0, 0, -1, 1);
    end
    tbl_active = 0;

    fill_random();
    run_layer(0, 0, 1, -1, 1);

    fill_random();
    run_layer(1, 1, 0, 30, 0);
    fill_random();
    run_layer(0, 0, 0, -1, 1);

    for (int i = 0; i < 3; i++) begin
      fill_random();
      run_layer(1, 1, 0, -1, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/bconv_layer_ctrl.md
# bconv_layer_ctrl

Sequencer for one binary convolution layer on the 28×28 binary image path. It accepts a bank of 3×3 binary kernels and a 28-row image over valid/ready streams, buffers them, then sweeps every kernel over the image. Each cycle it produces one 26-bit output row: XNOR-popcount-threshold per window. It sits between the host/capture interface and the next BNN layer, and replaces the free-running layer interface with an explicit start/busy/done and backpressured output.

## Interface
- `IMG_W`, 28, image width and height in pixels (square)
- `K`, 3, kernel side (fixed 3; not for override)
- `NUM_KERNELS`, 4, kernels per layer run
- `THRESH`, 5, output bit is 1 when the XNOR popcount is ≥ THRESH (range 0..9)
- `clk` in 1: single clock, rising edge
- `rst_n` in 1: asynchronous, active-low reset
- `start` in 1: begin a layer run; sampled only in IDLE
- `busy` out 1: high in every state except IDLE
- `done` out 1: one-cycle pulse at end of run
- `kern_valid` / `kern_ready` in/out 1: kernel stream handshake
- `kern_data` in 9: bit 3r+c = kernel[r][c]
- `img_row_valid` / `img_row_ready` in/out 1: image row handshake; rows arrive in order 0..27
- `img_row_data` in IMG_W: bit c = pixel column c
- `out_valid` / `out_ready` out/in 1: output row handshake
- `out_data` out OUT_W (=IMG_W−2): bit x = output column x
- `out_kidx` out clog2(NUM_KERNELS): kernel index of the current row
- `out_row` out clog2(OUT_W): output row index 0..25

## Operation
- States: IDLE → LOAD_KERN → LOAD_IMG → RUN → DONE → IDLE.
- IDLE: `start`=1 → LOAD_KERN, kernel counter cleared.
- LOAD_KERN: `kern_ready`=1. Each `kern_valid && kern_ready` writes kernel slot kc and increments kc. After slot NUM_KERNELS−1 → LOAD_IMG.
- LOAD_IMG: `img_row_ready`=1. Each accepted row writes buffer row ir. After row IMG_W−1 → RUN with k=0, y=0.
- RUN: registered output row for (k,y), where `out_data[x]` = (popcount over r,c∈0..2 of ~(img[y+r][x+c] ^ kern[k][3r+c])) ≥ THRESH.
  - On `out_valid && out_ready`: y++. When y wraps from OUT_W−1 to 0, k++.
  - After the handshake for (NUM_KERNELS−1, OUT_W−1) → DONE.
- DONE: `done`=1 for one cycle → IDLE.
- Buffers are not cleared between runs; every run reloads all kernels and all rows.
- `start` outside IDLE is ignored. A `start` in the same cycle as DONE is ignored.
- Popcount is 4 bits wide (0..9). The comparison is unsigned.

## Timing
- Reset values: `busy`, `done`, `kern_ready`, `img_row_ready`, `out_valid` = 0; `out_data`, `out_kidx`, `out_row` = 0; state IDLE.
- `kern_ready` / `img_row_ready` are combinational from state. Full rate of one transfer per cycle is sustained.
- First `out_valid` appears 1 cycle after the last image row handshake.
- In RUN with `out_ready` held high: one row per cycle, NUM_KERNELS×OUT_W consecutive rows, no bubbles between kernels.
- Backpressure: while `out_valid && !out_ready`, `out_data`, `out_kidx` and `out_row` hold stable.
- `out_valid` deasserts in the cycle after the final handshake, the same cycle `done` pulses.
- Total run with no stalls: 1 + NUM_KERNELS + IMG_W + NUM_KERNELS×OUT_W + 1 cycles from `start` to `done`.
- Asserting `rst_n` low at any point aborts immediately to the reset values. There is no partial-output flush.

## Structure
- `bconv_pkg`: IMG_W, K, OUT_W, the popcount width, and the state enum typedef `bconv_state_t`.
- Sub-module `bconv_row_unit` (combinational):
  - Inputs: three IMG_W-bit rows, a 9-bit kernel and THRESH.
  - Output: the OUT_W-bit row.
  - Built from OUT_W instances of the window XNOR-popcount-compare.
- `bconv_layer_ctrl` holds the FSM, counters, kernel and image buffers, and the output register.

## Test plan
- Reset mid-RUN: assert `rst_n` low with `out_valid`=1 → all outputs 0 next edge. After release, a fresh `start` completes a full run correctly.
- Checkerboard rows:
  - Stimulus: every row = 28'hAAAAAAA, kernel 0 = rows 101/010/101 (kern_data 9'b101_010_101), THRESH=5.
  - Required: every output row for k=0 equals 26'h2AAAAAA. Odd x gives popcount 6; even x gives popcount 3.
- Uniform: all-ones image, kernel 9'h1FF → 26'h3FFFFFF. Kernel 9'h000 → 26'h0000000. THRESH=0 with kernel 9'h000 → 26'h3FFFFFF.
- Ordering and count: NUM_KERNELS=4, `out_ready` tied high → exactly 104 rows; (`out_kidx`, `out_row`) = (0,0)…(0,25),(1,0)…(3,25); `done` one pulse, cycle count per formula.
- Backpressure:
  - Stimulus: random `out_ready` (≈50%) and random gaps on `kern_valid` / `img_row_valid`.
  - Required: output rows identical to the no-stall run, data stable during every stall, no dropped or duplicated rows.
- Spurious `start`: pulse `start` during LOAD_IMG, during RUN, and in the DONE cycle → no state change and no second run.
